// File: rtl/siso_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : siso_arb_pkg
//  Description : Default parameters and the delay-line stage record shared
//                by the siso_arb arbiter and its siso_line delay line.
//  Revision    : 1.0  initial release
// ============================================================================
package siso_arb_pkg;

    localparam int DEF_DATA_WID = 8;
    localparam int DEF_DEPTH    = 5;
    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_MAX_OUT  = 2;
    localparam int DEF_ID_W     = $clog2(DEF_NUM_REQ);

    // One delay-line stage at the default widths. The valid flag is the
    // most significant field, so a flattened record carries it in its MSB.
    typedef struct packed {
        logic                    valid;
        logic [DEF_ID_W-1:0]     id;
        logic [DEF_DATA_WID-1:0] data;
    } stage_t;

    // Width of a flattened {valid, id, data} record.
    function automatic int rec_width(input int id_w, input int data_wid);
        return 1 + id_w + data_wid;
    endfunction

endpackage
`default_nettype wire

// File: rtl/siso_line.sv
`default_nettype none
// ============================================================================
//  Module      : siso_line
//  Description : DEPTH-stage record-wide shift register with shift enable and
//                synchronous reset. The MSB of each record is its valid flag.
//  Revision    : 1.0  initial release
// ============================================================================
module siso_line #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             any_valid
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift register: reset clears every record, otherwise advance one stage per enabled edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (shift_en) begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign dout = r_stage[DEPTH-1];

    // Occupancy flag: OR of the valid bit (MSB) of every stage
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid = any_valid | r_stage[i][WIDTH-1];
    end

endmodule
`default_nettype wire

// File: rtl/siso_arb.sv
`default_nettype none
// ============================================================================
//  Module      : siso_arb
//  Description : Credit-limited round-robin arbiter feeding a shared fixed
//                latency delay line. Each requester may have at most MAX_OUT
//                items in flight; a credit returns in the cycle its item is
//                presented, so a full requester can be granted again then.
//  Revision    : 1.0  initial release
// ============================================================================
module siso_arb
    import siso_arb_pkg::*;
#(
    parameter int DATA_WID = DEF_DATA_WID,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_OUT  = DEF_MAX_OUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_WID-1:0] req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        hold,
    output logic                        out_valid,
    output logic [$clog2(NUM_REQ)-1:0]  out_id,
    output logic [DATA_WID-1:0]         out_data,
    output logic                        busy
);

    localparam int c_id_w  = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(MAX_OUT + 1);
    localparam int c_rec_w = rec_width(c_id_w, DATA_WID);
    localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUT);

    // Same field order as siso_arb_pkg::stage_t, sized for this instance.
    typedef struct packed {
        logic                valid;
        logic [c_id_w-1:0]   id;
        logic [DATA_WID-1:0] data;
    } rec_t;

    logic [c_cnt_w-1:0]  r_cnt [NUM_REQ];
    logic [c_id_w-1:0]   r_ptr;

    logic [DATA_WID-1:0] w_req_word [NUM_REQ];
    logic [NUM_REQ-1:0]  w_eligible;
    logic [NUM_REQ-1:0]  w_dec;
    logic [NUM_REQ-1:0]  w_grant;
    logic [c_id_w-1:0]   w_gnt_id;
    logic [c_id_w-1:0]   w_idx;
    logic                w_found;
    logic                w_xfer;
    logic                w_any_valid;
    rec_t                w_stage0;
    rec_t                w_last;

    // Per-requester data slices, credit return and eligibility
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
            assign w_req_word[i] = req_data[i*DATA_WID +: DATA_WID];
            assign w_dec[i]      = out_valid && (out_id == c_id_w'(i));
            assign w_eligible[i] = req_valid[i] && ((r_cnt[i] < c_max_out) || w_dec[i]);
        end
    endgenerate

    // Round-robin search starting after the last granted requester
    always_comb begin
        w_grant  = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = c_id_w'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && w_eligible[w_idx]) begin
                w_found         = 1'b1;
                w_grant[w_idx]  = 1'b1;
                w_gnt_id        = w_idx;
            end
        end
        if (rst || hold) w_grant = '0;
    end

    assign req_ready = w_grant;
    assign w_xfer    = |w_grant;

    // Stage-0 record: the granted item, or a bubble
    always_comb begin
        w_stage0 = '0;
        if (w_xfer) begin
            w_stage0.valid = 1'b1;
            w_stage0.id    = w_gnt_id;
            w_stage0.data  = w_req_word[w_gnt_id];
        end
    end

    siso_line #(
        .DEPTH (DEPTH),
        .WIDTH (c_rec_w)
    ) u_line (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (!hold),
        .din       (w_stage0),
        .dout      (w_last),
        .any_valid (w_any_valid)
    );

    assign out_valid = w_last.valid & ~hold;
    assign out_id    = w_last.id;
    assign out_data  = w_last.data;
    assign busy      = w_any_valid;

    // Round-robin pointer: remembers the last requester that transferred
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= c_id_w'(NUM_REQ - 1);
        end else if (w_xfer) begin
            r_ptr <= w_gnt_id;
        end
    end

    // In-flight credit counters; simultaneous grant and return cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
        end else if (!hold) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_w'(1);
                end else if (!w_grant[i] && w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] - c_cnt_w'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
